// File: rtl/ad_align_n_pkg.sv
// Shared definitions for the N-channel ADC sample aligner: register map, FSM encoding and
// reset values.
package ad_align_n_pkg;

  localparam logic [7:0] REG_MASK = 8'h00;
  localparam logic [7:0] REG_TO   = 8'h01;
  localparam logic [7:0] REG_MISS = 8'h02;
  localparam logic [7:0] REG_OVR  = 8'h03;

  localparam logic [7:0] TIMEOUT_RST = 8'h40;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCollect = 2'd1,
    StEmit    = 2'd2
  } state_e;

endpackage

// File: rtl/ad_align_n_if.sv
// fx configuration bus shared by the aligner and its host.
interface ad_align_n_if;

  logic [15:0] fx_waddr;
  logic        fx_wr;
  logic [7:0]  fx_data;
  logic        fx_rd;
  logic [15:0] fx_raddr;
  logic [7:0]  fx_q;

  modport master (
    output fx_waddr, fx_wr, fx_data, fx_rd, fx_raddr,
    input  fx_q
  );

  modport slave (
    input  fx_waddr, fx_wr, fx_data, fx_rd, fx_raddr,
    output fx_q
  );

endinterface

// File: rtl/ad_align_regs.sv
// fx register block of the aligner: channel mask, timeout and the saturating
// miss/overwrite counters.
module ad_align_regs
  import ad_align_n_pkg::*;
#(
  parameter int unsigned N_CH = 3
) (
  input  logic            clk_sys,
  input  logic            rst_n,
  ad_align_n_if.slave     fx,
  input  logic [5:0]      mod_id,
  input  logic            miss_inc,
  input  logic [3:0]      ovr_add,
  output logic [N_CH-1:0] mask,
  output logic [7:0]      timeout
);

  logic [N_CH-1:0] mask_q;
  logic [7:0]      to_q, miss_q, ovr_q, rdata, mask_rd;
  logic            wsel, rsel, clr;
  logic [8:0]      ovr_sum;
  logic            unused_addr;

  assign mask        = mask_q;
  assign timeout     = to_q;
  assign unused_addr = ^{fx.fx_waddr[15:14], fx.fx_raddr[15:14]};

  always_comb begin
    wsel    = fx.fx_wr && (fx.fx_waddr[13:8] == mod_id);
    rsel    = fx.fx_rd && (fx.fx_raddr[13:8] == mod_id);
    // Writing either counter offset clears both counters.
    clr     = wsel && ((fx.fx_waddr[7:0] == REG_MISS) || (fx.fx_waddr[7:0] == REG_OVR));
    mask_rd = '0;
    mask_rd[N_CH-1:0] = mask_q;
    ovr_sum = {1'b0, ovr_q} + {5'b0, ovr_add};
    case (fx.fx_raddr[7:0])
      REG_MASK: rdata = mask_rd;
      REG_TO:   rdata = to_q;
      REG_MISS: rdata = miss_q;
      REG_OVR:  rdata = ovr_q;
      default:  rdata = '0;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      mask_q  <= '1;
      to_q    <= TIMEOUT_RST;
      miss_q  <= '0;
      ovr_q   <= '0;
      fx.fx_q <= '0;
    end else begin
      if (wsel && (fx.fx_waddr[7:0] == REG_MASK)) mask_q <= fx.fx_data[N_CH-1:0];
      if (wsel && (fx.fx_waddr[7:0] == REG_TO))   to_q   <= fx.fx_data;
      if (clr) begin
        miss_q <= '0;
        ovr_q  <= '0;
      end else begin
        if (miss_inc && (miss_q != 8'hff)) miss_q <= miss_q + 8'd1;
        ovr_q <= ovr_sum[8] ? 8'hff : ovr_sum[7:0];
      end
      fx.fx_q <= rsel ? rdata : '0;
    end
  end

endmodule

// File: rtl/ad_align_n.sv
// Collects one sample per enabled ADC channel into a timestamped frame and replays it as a
// serial per-channel stream, with a us-based timeout for channels that never arrive.
module ad_align_n
  import ad_align_n_pkg::*;
#(
  parameter int unsigned N_CH = 3,
  parameter int unsigned DW   = 24
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             pluse_us,
  input  logic [N_CH*DW-1:0] ad_data,
  input  logic [N_CH-1:0]  ad_vld,
  input  logic [31:0]      utc_sec,
  input  logic [31:0]      now_ns,
  output logic [DW-1:0]    out_data,
  output logic [2:0]       out_ch,
  output logic             out_vld,
  output logic             out_sof,
  output logic             out_eof,
  output logic             out_miss,
  output logic [31:0]      out_utc,
  output logic [31:0]      out_ns,
  ad_align_n_if.slave      fx,
  input  logic [5:0]       mod_id
);

  state_e          state_q, state_d;
  logic [N_CH-1:0] cfg_mask, mask_q, flag_q, flag_d, pend_q, pend_d, buf_full_q;
  logic [N_CH-1:0] cap, cap_en, sel_oh;
  logic [7:0]      cfg_to, us_cnt_q;
  logic [DW-1:0]   hold_q [N_CH];
  logic [DW-1:0]   buf_q  [N_CH];
  logic            first_q, early_q;
  logic [31:0]     frame_utc_q, frame_ns_q, early_utc_q, early_ns_q;
  logic            start, go_emit, emitting, all_full, timeout_hit, miss_inc, sel_full;
  logic [3:0]      ovr_add;
  logic [2:0]      sel_idx;
  logic [DW-1:0]   sel_data;

  ad_align_regs #(
    .N_CH(N_CH)
  ) u_regs (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .fx      (fx),
    .mod_id  (mod_id),
    .miss_inc(miss_inc),
    .ovr_add (ovr_add),
    .mask    (cfg_mask),
    .timeout (cfg_to)
  );

  // In IDLE the live mask gates capture; afterwards the mask latched for the frame does.
  always_comb begin
    cap_en      = (state_q == StIdle) ? cfg_mask : mask_q;
    cap         = ad_vld & cap_en;
    all_full    = (flag_q & mask_q) == mask_q;
    timeout_hit = pluse_us && (({1'b0, us_cnt_q} + 9'd1) >= {1'b0, cfg_to});
    flag_d      = go_emit ? cap : (flag_q | cap);
    ovr_add     = '0;
    if (!go_emit) begin
      for (int k = 0; k < int'(N_CH); k++) begin
        if (cap[k] && flag_q[k]) ovr_add = ovr_add + 4'd1;
      end
    end
  end

  // Lowest pending channel is emitted next.
  always_comb begin
    sel_idx  = '0;
    sel_oh   = '0;
    sel_data = '0;
    sel_full = 1'b0;
    for (int k = int'(N_CH) - 1; k >= 0; k--) begin
      if (pend_q[k]) begin
        sel_idx     = 3'(k);
        sel_oh      = '0;
        sel_oh[k]   = 1'b1;
        sel_data    = buf_q[k];
        sel_full    = buf_full_q[k];
      end
    end
    pend_d   = pend_q & ~sel_oh;
    miss_inc = emitting && !sel_full;
  end

  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    go_emit  = 1'b0;
    emitting = 1'b0;
    unique case (state_q)
      StIdle: begin
        if ((cfg_mask != '0) && ((cap != '0) || early_q)) begin
          state_d = StCollect;
          start   = 1'b1;
        end
      end
      StCollect: begin
        if (all_full || timeout_hit) begin
          state_d = StEmit;
          go_emit = 1'b1;
        end
      end
      StEmit: begin
        emitting = 1'b1;
        if (pend_d == '0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mask_q      <= '0;
      flag_q      <= '0;
      pend_q      <= '0;
      buf_full_q  <= '0;
      first_q     <= 1'b0;
      early_q     <= 1'b0;
      us_cnt_q    <= '0;
      frame_utc_q <= '0;
      frame_ns_q  <= '0;
      early_utc_q <= '0;
      early_ns_q  <= '0;
      out_vld     <= 1'b0;
      out_sof     <= 1'b0;
      out_eof     <= 1'b0;
      out_miss    <= 1'b0;
      out_ch      <= '0;
      out_data    <= '0;
      out_utc     <= '0;
      out_ns      <= '0;
    end else begin
      state_q <= state_d;
      flag_q  <= flag_d;
      if (start) begin
        mask_q      <= cfg_mask;
        us_cnt_q    <= '0;
        early_q     <= 1'b0;
        frame_utc_q <= early_q ? early_utc_q : utc_sec;
        frame_ns_q  <= early_q ? early_ns_q : now_ns;
      end else if ((state_q == StCollect) && pluse_us && (us_cnt_q != 8'hff)) begin
        us_cnt_q <= us_cnt_q + 8'd1;
      end
      // A capture after the frame closed opens the next frame; remember when it arrived.
      if ((go_emit || emitting) && (cap != '0) && !early_q) begin
        early_q     <= 1'b1;
        early_utc_q <= utc_sec;
        early_ns_q  <= now_ns;
      end
      if (go_emit) begin
        buf_full_q <= flag_q & mask_q;
        pend_q     <= mask_q;
        first_q    <= 1'b1;
      end else if (emitting) begin
        pend_q  <= pend_d;
        first_q <= 1'b0;
      end
      out_vld  <= emitting;
      out_sof  <= emitting && first_q;
      out_eof  <= emitting && (pend_d == '0);
      out_miss <= miss_inc;
      out_ch   <= emitting ? sel_idx : '0;
      out_data <= (emitting && sel_full) ? sel_data : '0;
      if (emitting) begin
        out_utc <= frame_utc_q;
        out_ns  <= frame_ns_q;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(N_CH); k++) begin
        hold_q[k] <= '0;
        buf_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < int'(N_CH); k++) begin
        if (cap[k])  hold_q[k] <= ad_data[k*DW +: DW];
        if (go_emit) buf_q[k]  <= hold_q[k];
      end
    end
  end

endmodule

// File: doc/ad_align_n.md
# ad_align_n

Parametrised N-channel ADC sample aligner that sits between the per-channel `ad_top` instances and `dsp_top` on the slave FPGA. It collects one sample from each enabled channel into a frame, stamps the frame with `utc_sec`/`now_ns` at the first arrival, and emits the frame as a serial per-channel stream. Channel count and sample width are parameters, and the channel mask and timeout are runtime-configurable over the fx bus. It replaces the fixed three-channel wiring with a timeout-protected, counted alignment stage.

## Interface
- `N_CH`, 3: number of ADC channels, 1..8
- `DW`, 24: sample width in bits
- `clk_sys`  in  1  system clock; the only clock
- `rst_n`  in  1  asynchronous, active-low reset
- `pluse_us`  in  1  one-cycle strobe every 1 us
- `ad_data`  in  N_CH*DW  channel k occupies bits [k*DW +: DW]
- `ad_vld`  in  N_CH  per-channel one-cycle sample strobe
- `utc_sec`, `now_ns`  in  32 each  time base
- `out_data`  out  DW  emitted sample
- `out_ch`  out  3  channel index of the emitted sample
- `out_vld`  out  1  emitted-sample strobe
- `out_sof`, `out_eof`  out  1 each  first and last sample of a frame
- `out_miss`  out  1  sample missing; `out_data` is 0
- `out_utc`, `out_ns`  out  32 each  frame timestamp, held for the whole frame
- `fx_waddr[15:0]`, `fx_wr`, `fx_data[7:0]`, `fx_rd`, `fx_raddr[15:0]`  in  fx bus
- `fx_q`  out  8  fx bus read data
- `mod_id`  in  6  module id

## Operation
- Module is selected when `addr[13:8]==mod_id`; `addr[7:0]` is the register offset.
- `0x00` MASK (rw, reset `2^N_CH-1`): channel enable. Bits at or above N_CH read as 0.
- `0x01` TIMEOUT (rw, reset 0x40): timeout in us.
- `0x02` MISS (ro): saturating 8-bit count of missing samples.
- `0x03` OVR (ro): saturating 8-bit count of overwritten samples.
- A write to `0x02` or `0x03` clears both counters.
- Per channel: a holding register and a full flag. When `ad_vld[k]` is asserted and channel k is enabled, the sample is captured and the flag is set. If the flag is already set, the sample overwrites the held value and OVR increments.
- States:
  - IDLE → COLLECT on the first enabled capture. On entry, latch MASK, `utc_sec` and `now_ns` of that cycle, and clear the us counter.
  - COLLECT → EMIT when every latched-mask channel is full, or when the us counter reaches TIMEOUT.
  - On COLLECT → EMIT: copy the holding registers to the emit buffer and clear all flags. A `ad_vld` in that same cycle sets its flag again for the next frame.
  - EMIT: output one enabled channel per cycle in ascending index order. A missing channel gives `out_data=0` and `out_miss=1`, and MISS increments. → IDLE after the last channel.
- MASK==0: stay in IDLE and ignore all samples.
- A MASK write mid-frame takes effect at the next IDLE → COLLECT transition.
- TIMEOUT==0 means a timeout on the first `pluse_us` after COLLECT entry.
- No backpressure; the consumer must accept every `out_vld`.

## Timing
- Reset values: all outputs 0, all counters 0, state IDLE, all flags cleared.
- Reset mid-frame discards the frame; there is no partial emit.
- Latency: the capture cycle that completes the frame (edge t) gives first `out_vld` at edge t+2.
- EMIT lasts popcount(MASK) consecutive cycles.
- `out_sof` and `out_eof` coincide when a single channel is enabled.
- fx read latency is 1 cycle; `fx_q` is registered and is 0 when not selected or `fx_rd` is low.
- fx write takes effect on the edge where `fx_wr` is high.

## Structure
- Shared package holds: register offsets (`REG_MASK`, `REG_TO`, `REG_MISS`, `REG_OVR`), the state encoding, and the `TIMEOUT` reset value.
- One sub-module: `ad_align_regs`, containing the fx decode, the registers, the saturating counters and the `fx_q` mux.

## Test plan
- N_CH=3, MASK=7, samples 0x000011/0x000022/0x000033 on channels 0/1/2 at cycles 5/9/13:
  - `out_vld` at cycles 15..17 with ch 0,1,2 and data 11/22/33.
  - `out_sof` at cycle 15, `out_eof` at cycle 17.
  - `out_utc`/`out_ns` equal the values sampled at cycle 5.
- MASK=7, TIMEOUT=2, only channel 0 supplies a sample:
  - Emit after two `pluse_us` pulses; ch1 and ch2 have `out_miss=1` and data 0.
  - MISS reads 2.
- Channel 1 strobes twice before channel 2 arrives:
  - The second value is emitted; OVR reads 1.
  - Write `0x03`: MISS and OVR both read 0.
- MASK=0x05:
  - Frame emits ch0 then ch2 only, over 2 cycles.
  - A `ad_vld[1]` strobe is ignored.
- `ad_vld[0]` in the COLLECT→EMIT cycle: that sample opens the next frame after the current EOF.
- `rst_n` asserted during EMIT: all outputs go to 0 immediately; after release, no residual `out_vld`.
